// File: rtl/execute_stage.sv
// execute_stage: RSA ASIP execute stage with single-cycle ALU and multi-cycle interleaved a*b mod m
// Ports: clk/reset (sync, active-high); in_valid/in_ready upstream handshake; op, src_a, src_b, src_m operands;
// write_data_in, mem_write_in, dst_in sideband; out_valid, result, write_data, mem_write, dst_out, err registered outputs.
module execute_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] src_a,
    input  logic [N-1:0] src_b,
    input  logic [N-1:0] src_m,
    input  logic [N-1:0] write_data_in,
    input  logic         mem_write_in,
    input  logic [3:0]   dst_in,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic [N-1:0] write_data,
    output logic         mem_write,
    output logic [3:0]   dst_out,
    output logic         err
);
    localparam int IW = $clog2(N);
    typedef enum logic {IDLE, MODMUL} state_t;
    state_t          r_state, w_next;
    logic [N-1:0]    r_a, r_b, r_m, r_wd;
    logic [N+1:0]    r_p;
    logic [IW-1:0]   r_i;
    logic            r_mw;
    logic [3:0]      r_dst;
    logic            w_accept, w_mm_ok, w_start, w_done, w_alu_err;
    logic [N-1:0]    w_alu;
    logic [N+1:0]    w_m, w_t0, w_t1, w_t2, w_t3;
    // m = 0 fails automatically since nothing is unsigned-less-than zero
    assign w_mm_ok   = (src_a < src_m) && (src_b < src_m);
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && op == 3'b110 && w_mm_ok;
    assign w_alu_err = op == 3'b111 || (op == 3'b110 && !w_mm_ok);
    assign w_done    = r_state == MODMUL && r_i == '0;
    // MODMUL and reserved ops yield 0 here; the violating-MODMUL path reports that 0 with err
    always_comb begin
        w_alu = op == 3'b000 ? src_a + src_b :
                op == 3'b001 ? src_a - src_b :
                op == 3'b010 ? src_a & src_b :
                op == 3'b011 ? src_a | src_b :
                op == 3'b100 ? src_a ^ src_b :
                op == 3'b101 ? src_a * src_b : '0;
    end
    // One interleaved step: P stays below M, so each conditional subtract fires at most once
    always_comb begin
        w_m  = {2'b00, r_m};
        w_t0 = r_p << 1;
        w_t1 = w_t0 >= w_m ? w_t0 - w_m : w_t0;
        w_t2 = w_t1 + (r_b[r_i] ? {2'b00, r_a} : '0);
        w_t3 = w_t2 >= w_m ? w_t2 - w_m : w_t2;
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE ? (w_start ? MODMUL : IDLE) : (w_done ? IDLE : MODMUL);
    end
    always_comb begin
        in_ready = r_state == IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            write_data <= '0;
            mem_write  <= 1'b0;
            dst_out    <= '0;
            err        <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_m        <= '0;
            r_p        <= '0;
            r_i        <= '0;
            r_wd       <= '0;
            r_mw       <= 1'b0;
            r_dst      <= '0;
        end else begin
            out_valid <= 1'b0;
            mem_write <= 1'b0;
            if (w_accept && !w_start) begin
                out_valid  <= 1'b1;
                result     <= w_alu;
                err        <= w_alu_err;
                write_data <= write_data_in;
                mem_write  <= mem_write_in;
                dst_out    <= dst_in;
            end
            if (w_start) begin
                r_a   <= src_a;
                r_b   <= src_b;
                r_m   <= src_m;
                r_p   <= '0;
                r_i   <= IW'(N - 1);
                r_wd  <= write_data_in;
                r_mw  <= mem_write_in;
                r_dst <= dst_in;
            end
            if (r_state == MODMUL) begin
                r_p <= w_t3;
                r_i <= r_i - 1'b1;
                if (w_done) begin
                    out_valid  <= 1'b1;
                    result     <= w_t3[N-1:0];
                    err        <= 1'b0;
                    write_data <= r_wd;
                    mem_write  <= r_mw;
                    dst_out    <= r_dst;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed scoreboard bench for execute_stage
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0, src_m = '0, write_data_in = '0;
    logic        mem_write_in = 1'b0;
    logic [3:0]  dst_in = '0;
    logic        out_valid, mem_write, err;
    logic [31:0] result, write_data;
    logic [3:0]  dst_out;
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] wd;
        logic        mw;
        logic [3:0]  dst;
        logic        e;
    } exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    execute_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src_a(src_a), .src_b(src_b), .src_m(src_m), .write_data_in(write_data_in),
        .mem_write_in(mem_write_in), .dst_in(dst_in), .out_valid(out_valid), .result(result),
        .write_data(write_data), .mem_write(mem_write), .dst_out(dst_out), .err(err)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            exp_t e;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid got result=%h err=%b exp no output", result, err);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                assert ({result, write_data, mem_write, dst_out, err} === e) else begin
                    errors++;
                    $error("FAIL out got res=%h wd=%h mw=%b dst=%h err=%b exp res=%h wd=%h mw=%b dst=%h err=%b",
                           result, write_data, mem_write, dst_out, err, e.res, e.wd, e.mw, e.dst, e.e);
                end
            end
        end
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                        input logic [31:0] wd, input logic mw, input logic [3:0] d,
                        input logic [31:0] er, input logic ee);
        @(negedge clk);
        op = o; src_a = a; src_b = b; src_m = m;
        write_data_in = wd; mem_write_in = mw; dst_in = d; in_valid = 1'b1;
        q.push_back('{res: er, wd: wd, mw: mw, dst: d, e: ee});
    endtask
    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        op = '0;
    endtask
    // Counts negedges from the issuing negedge until out_valid; in_valid is held until then
    task automatic wait_valid(input string tag, input int exp_n);
        int n = 0;
        int low = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (!in_ready) low++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(exp_n));
        if (exp_n > 1) check({tag, "_rdy_low"}, 64'(low), 64'(exp_n - 1));
        check({tag, "_rdy_end"}, 64'(in_ready), 64'd1);
    endtask
    initial begin
        logic [63:0] prod;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_a", {out_valid, result, mem_write, dst_out, err}, 64'd0);
        check("rst_b", {32'd0, write_data}, 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd1);
        send(3'b000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hA5A5_A5A5, 1'b1, 4'd5, 32'd1, 1'b0);
        wait_valid("add", 1);
        @(negedge clk);
        check("mw_deassert", {62'd0, out_valid, mem_write}, 64'd0);
        send(3'b001, 32'd3, 32'd5, 32'd0, 32'h1, 1'b0, 4'd1, 32'hFFFF_FFFE, 1'b0);
        send(3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0, 32'h2, 1'b1, 4'd2, 32'h0F0F_F0F0, 1'b0);
        check("b2b_v1", 64'(out_valid), 64'd1);
        send(3'b101, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'h3, 1'b0, 4'd3, 32'h0001_0000, 1'b0);
        check("b2b_v2", 64'(out_valid), 64'd1);
        idle();
        check("b2b_v3", 64'(out_valid), 64'd1);
        send(3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'h4, 1'b0, 4'd4, 32'h0F00_0F00, 1'b0);
        send(3'b011, 32'hFF00_0000, 32'h0000_00FF, 32'd0, 32'h5, 1'b0, 4'd6, 32'hFF00_00FF, 1'b0);
        idle();
        idle();
        send(3'b110, 32'd7, 32'd9, 32'd11, 32'hDEAD_BEEF, 1'b1, 4'd7, 32'd8, 1'b0);
        wait_valid("mm_7_9", 33);
        idle();
        send(3'b110, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h6, 1'b0, 4'd8, 32'd1, 1'b0);
        wait_valid("mm_big", 33);
        send(3'b110, 32'h1234_5678, 32'd0, 32'h7FFF_FFFF, 32'h7, 1'b0, 4'd9, 32'd0, 1'b0);
        wait_valid("mm_b0", 33);
        prod = (64'h1234_5678 * 64'h0ABC_DEF1) % 64'hFEDC_BA97;
        send(3'b110, 32'h1234_5678, 32'h0ABC_DEF1, 32'hFEDC_BA97, 32'h8, 1'b1, 4'd10, prod[31:0], 1'b0);
        wait_valid("mm_gen", 33);
        send(3'b110, 32'd12, 32'd3, 32'd11, 32'h9, 1'b0, 4'd11, 32'd0, 1'b1);
        wait_valid("mm_viol", 1);
        send(3'b110, 32'd0, 32'd0, 32'd0, 32'hA, 1'b0, 4'd12, 32'd0, 1'b1);
        wait_valid("mm_m0", 1);
        send(3'b111, 32'd1, 32'd2, 32'd3, 32'hB, 1'b1, 4'd13, 32'd0, 1'b1);
        wait_valid("rsvd", 1);
        send(3'b000, 32'd10, 32'd20, 32'd0, 32'hC, 1'b0, 4'd14, 32'd30, 1'b0);
        wait_valid("add_clr", 1);
        send(3'b110, 32'h0000_1234, 32'h0000_5678, 32'h000F_FFF1, 32'hD, 1'b1, 4'd15, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("abort_a", {out_valid, result, mem_write, dst_out, err}, 64'd0);
        check("abort_b", {32'd0, write_data}, 64'd0);
        check("abort_rdy", 64'(in_ready), 64'd1);
        send(3'b110, 32'd7, 32'd9, 32'd11, 32'h5555_AAAA, 1'b0, 4'd3, 32'd8, 1'b0);
        wait_valid("mm_after_rst", 33);
        repeat (3) idle();
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
